// File: rtl/reorder_buffer_if.sv
// Reorder buffer port bundle: rename allocation, FU completion,
// flush and in-order retirement toward the free list / arch map.
interface reorder_buffer_if #(
  parameter int IDX_W  = 4,
  parameter int AREG_W = 5,
  parameter int PTAG_W = 6
);
  logic              alloc_valid;
  logic              alloc_ready;
  logic [AREG_W-1:0] alloc_areg;
  logic [PTAG_W-1:0] alloc_pdest;
  logic [PTAG_W-1:0] alloc_pold;
  logic              alloc_regwrite;
  logic [IDX_W-1:0]  alloc_idx;
  logic              cmpl_valid;
  logic [IDX_W-1:0]  cmpl_idx;
  logic              flush;
  logic              retire_valid;
  logic [AREG_W-1:0] retire_areg;
  logic [PTAG_W-1:0] retire_pdest;
  logic [PTAG_W-1:0] retire_pold;
  logic              retire_regwrite;
  logic [IDX_W:0]    count;
  logic              empty;

  modport master (
    output alloc_valid, alloc_areg, alloc_pdest,
    output alloc_pold, alloc_regwrite,
    output cmpl_valid, cmpl_idx, flush,
    input  alloc_ready, alloc_idx,
    input  retire_valid, retire_areg, retire_pdest,
    input  retire_pold, retire_regwrite,
    input  count, empty
  );

  modport slave (
    input  alloc_valid, alloc_areg, alloc_pdest,
    input  alloc_pold, alloc_regwrite,
    input  cmpl_valid, cmpl_idx, flush,
    output alloc_ready, alloc_idx,
    output retire_valid, retire_areg, retire_pdest,
    output retire_pold, retire_regwrite,
    output count, empty
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer: allocate at tail,
// complete out of order, retire one done head entry per cycle.
module reorder_buffer #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int AREG_W = 5,
  parameter int PTAG_W = 6
) (
  input  logic           clk,
  input  logic           rstn,
  reorder_buffer_if.slave rob
);
  localparam logic [IDX_W:0] PTR_ONE = 1;

  logic [IDX_W:0]    head, tail;
  logic [DEPTH-1:0]  valid, done;
  logic [AREG_W-1:0] areg_q  [DEPTH];
  logic [PTAG_W-1:0] pdest_q [DEPTH];
  logic [PTAG_W-1:0] pold_q  [DEPTH];
  logic [DEPTH-1:0]  rw_q;

  logic [IDX_W-1:0] hidx, tidx;
  logic full, do_alloc, do_cmpl, do_retire;

  assign hidx = head[IDX_W-1:0];
  assign tidx = tail[IDX_W-1:0];

  // Wrap bits differ with equal indices: tail lapped head.
  assign full = (hidx == tidx) &&
                (head[IDX_W] != tail[IDX_W]);

  assign do_alloc  = rob.alloc_valid & ~full;
  assign do_cmpl   = rob.cmpl_valid & valid[rob.cmpl_idx];
  assign do_retire = valid[hidx] & done[hidx];

  assign rob.alloc_ready = ~full;
  assign rob.alloc_idx   = tidx;
  assign rob.count       = tail - head;
  assign rob.empty       = (head == tail);

  assign rob.retire_valid    = do_retire;
  assign rob.retire_areg     = do_retire ? areg_q[hidx]  : '0;
  assign rob.retire_pdest    = do_retire ? pdest_q[hidx] : '0;
  assign rob.retire_pold     = do_retire ? pold_q[hidx]  : '0;
  assign rob.retire_regwrite = do_retire & rw_q[hidx];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head  <= '0;
      tail  <= '0;
      valid <= '0;
      done  <= '0;
    end else if (rob.flush) begin
      head  <= '0;
      tail  <= '0;
      valid <= '0;
      done  <= '0;
    end else begin
      if (do_alloc) begin
        valid[tidx] <= 1'b1;
        done[tidx]  <= 1'b0;
        tail        <= tail + PTR_ONE;
      end
      if (do_cmpl) begin
        done[rob.cmpl_idx] <= 1'b1;
      end
      if (do_retire) begin
        valid[hidx] <= 1'b0;
        done[hidx]  <= 1'b0;
        head        <= head + PTR_ONE;
      end
    end
  end

  // Payload is only read behind valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_alloc && !rob.flush) begin
      areg_q[tidx]  <= rob.alloc_areg;
      pdest_q[tidx] <= rob.alloc_pdest;
      pold_q[tidx]  <= rob.alloc_pold;
      rw_q[tidx]    <= rob.alloc_regwrite;
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: allocations queue expected
// retires; a negedge monitor checks retire timing and contents.
module tb_reorder_buffer;
  logic clk = 1'b0;
  logic rstn;

  reorder_buffer_if rif ();

  reorder_buffer dut (
    .clk  (clk),
    .rstn (rstn),
    .rob  (rif.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] idx;
    logic [4:0] areg;
    logic [5:0] pdest;
    logic [5:0] pold;
    logic       rw;
  } ent_t;

  ent_t       sb[$];
  bit [15:0]  mdone;
  logic [3:0] mtail;
  int         tests = 0;
  int         fails = 0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic set_alloc(input logic [4:0] a, input logic [5:0] pd,
                           input logic [5:0] po, input logic rw);
    rif.alloc_valid    = 1'b1;
    rif.alloc_areg     = a;
    rif.alloc_pdest    = pd;
    rif.alloc_pold     = po;
    rif.alloc_regwrite = rw;
  endtask

  task automatic idle();
    rif.alloc_valid = 1'b0;
    rif.cmpl_valid  = 1'b0;
    rif.flush       = 1'b0;
  endtask

  // Advance one clock; model acceptance uses the pre-edge occupancy.
  task automatic cycle();
    ent_t e;
    if (rif.alloc_valid && sb.size() < 16) begin
      e.idx   = mtail;
      e.areg  = rif.alloc_areg;
      e.pdest = rif.alloc_pdest;
      e.pold  = rif.alloc_pold;
      e.rw    = rif.alloc_regwrite;
      sb.push_back(e);
      mdone[mtail] = 1'b0;
      mtail++;
    end
    @(posedge clk);
    #1;
    if (rif.flush) begin
      sb.delete();
      mdone = '0;
      mtail = '0;
    end else if (rif.cmpl_valid) begin
      mdone[rif.cmpl_idx] = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      ent_t e;
      bit   ev;
      ev = (sb.size() > 0) && mdone[sb[0].idx];
      chk("retire_valid", {31'd0, rif.retire_valid}, {31'd0, ev});
      if (ev) begin
        e = sb.pop_front();
        mdone[e.idx] = 1'b0;
        chk("retire_areg",  {27'd0, rif.retire_areg},  {27'd0, e.areg});
        chk("retire_pdest", {26'd0, rif.retire_pdest}, {26'd0, e.pdest});
        chk("retire_pold",  {26'd0, rif.retire_pold},  {26'd0, e.pold});
        chk("retire_rw", {31'd0, rif.retire_regwrite}, {31'd0, e.rw});
      end else begin
        chk("retire_zero",
            {14'd0, rif.retire_areg, rif.retire_pdest,
             rif.retire_pold, rif.retire_regwrite}, 32'd0);
      end
    end
  end

  task automatic chk_reset_outputs(input string n);
    chk({n, "_ready"}, {31'd0, rif.alloc_ready}, 32'd1);
    chk({n, "_empty"}, {31'd0, rif.empty}, 32'd1);
    chk({n, "_count"}, {27'd0, rif.count}, 32'd0);
    chk({n, "_idx"}, {28'd0, rif.alloc_idx}, 32'd0);
    chk({n, "_rvalid"}, {31'd0, rif.retire_valid}, 32'd0);
    chk({n, "_rfields"},
        {14'd0, rif.retire_areg, rif.retire_pdest,
         rif.retire_pold, rif.retire_regwrite}, 32'd0);
  endtask

  initial begin
    logic [3:0] prev;
    rstn  = 1'b0;
    mdone = '0;
    mtail = '0;
    prev  = '0;
    idle();
    rif.alloc_areg     = '0;
    rif.alloc_pdest    = '0;
    rif.alloc_pold     = '0;
    rif.alloc_regwrite = 1'b0;
    rif.cmpl_idx       = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rstn = 1'b1;

    // Fill all 16 entries, then try a 17th.
    for (int i = 0; i < 16; i++) begin
      chk("fill_idx", {28'd0, rif.alloc_idx}, {28'd0, mtail});
      set_alloc(5'(i), 6'(32 + i), 6'(i), 1'b1);
      cycle();
    end
    set_alloc(5'd16, 6'd48, 6'd20, 1'b1);
    chk("full_count", {27'd0, rif.count}, 32'd16);
    chk("full_ready", {31'd0, rif.alloc_ready}, 32'd0);
    cycle();
    chk("full_hold_count", {27'd0, rif.count}, 32'd16);
    chk("full_hold_idx", {28'd0, rif.alloc_idx}, 32'd0);

    // Full ROB retiring head while alloc is pending.
    rif.alloc_valid = 1'b0;
    rif.cmpl_valid  = 1'b1;
    rif.cmpl_idx    = 4'd0;
    cycle();
    rif.cmpl_valid = 1'b0;
    set_alloc(5'd17, 6'd49, 6'd21, 1'b1);
    chk("fullret_ready", {31'd0, rif.alloc_ready}, 32'd0);
    cycle();
    chk("fullret_count", {27'd0, rif.count}, 32'd15);
    chk("fullret_ready1", {31'd0, rif.alloc_ready}, 32'd1);
    cycle();
    chk("fullret_accept", {27'd0, rif.count}, 32'd16);
    idle();
    rif.flush = 1'b1;
    cycle();
    idle();
    chk("flush1_count", {27'd0, rif.count}, 32'd0);
    chk("flush1_empty", {31'd0, rif.empty}, 32'd1);

    // Out-of-order completion, in-order retire.
    for (int i = 0; i < 3; i++) begin
      set_alloc(5'(3 + i), 6'(10 + i), 6'(50 + i), 1'b1);
      cycle();
    end
    idle();
    for (int i = 2; i >= 0; i--) begin
      rif.cmpl_valid = 1'b1;
      rif.cmpl_idx   = 4'(i);
      cycle();
    end
    idle();
    repeat (4) cycle();
    chk("ooo_count", {27'd0, rif.count}, 32'd0);
    chk("ooo_empty", {31'd0, rif.empty}, 32'd1);

    // Steady state: one alloc and one retire per cycle.
    for (int k = 0; k < 40; k++) begin
      chk("steady_idx", {28'd0, rif.alloc_idx}, {28'd0, mtail});
      set_alloc(5'(k), 6'(k + 8), 6'(63 - k), k[0]);
      rif.cmpl_valid = (k > 0);
      rif.cmpl_idx   = prev;
      prev = mtail;
      cycle();
      if (k >= 1)
        chk("steady_count", {27'd0, rif.count}, 32'd2);
    end
    idle();
    rif.cmpl_valid = 1'b1;
    rif.cmpl_idx   = prev;
    cycle();
    idle();
    repeat (3) cycle();
    chk("steady_drain", {31'd0, rif.empty}, 32'd1);

    // Non-writing instruction still retires with its fields.
    set_alloc(5'd9, 6'd30, 6'd7, 1'b0);
    prev = mtail;
    cycle();
    idle();
    rif.cmpl_valid = 1'b1;
    rif.cmpl_idx   = prev;
    cycle();
    idle();
    repeat (3) cycle();

    // Flush with a simultaneous completion.
    prev = mtail;
    for (int i = 0; i < 5; i++) begin
      set_alloc(5'(20 + i), 6'(i + 1), 6'(40 + i), 1'b1);
      cycle();
    end
    idle();
    chk("pre_flush_count", {27'd0, rif.count}, 32'd5);
    rif.flush      = 1'b1;
    rif.cmpl_valid = 1'b1;
    rif.cmpl_idx   = prev;
    cycle();
    idle();
    chk("flush_count", {27'd0, rif.count}, 32'd0);
    chk("flush_empty", {31'd0, rif.empty}, 32'd1);
    chk("flush_idx", {28'd0, rif.alloc_idx}, 32'd0);
    cycle();

    // Asynchronous reset in the middle of a cycle.
    set_alloc(5'd1, 6'd2, 6'd3, 1'b1);
    cycle();
    idle();
    rif.cmpl_valid = 1'b1;
    rif.cmpl_idx   = 4'd0;
    cycle();
    idle();
    set_alloc(5'd4, 6'd5, 6'd6, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    sb.delete();
    mdone = '0;
    mtail = '0;
    idle();
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Recovery after reset.
    set_alloc(5'd11, 6'd22, 6'd33, 1'b1);
    cycle();
    idle();
    rif.cmpl_valid = 1'b1;
    rif.cmpl_idx   = 4'd0;
    cycle();
    idle();
    repeat (3) cycle();
    chk("final_drained", sb.size(), 32'd0);
    chk("final_empty", {31'd0, rif.empty}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
